// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared types and constants for the BCD digit counter.
//   state_t : carry-walk FSM states (IDLE, CALC, DONE)
//   BCD_W   : bits per BCD digit
//   BCD_MAX : largest legal digit value
// -----------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_add.sv
// -----------------------------------------------------------------------------
// bcd_digit_add
// Combinational single-digit BCD adder used by the serial carry walk.
// Ports:
//   digit     in  BCD_W : current digit value (0..9)
//   inc       in  1     : +1 request at this digit
//   carry_in  in  1     : carry from the digit below
//   digit_out out BCD_W : resulting digit (0..9)
//   carry_out out 1     : carry into the digit above
// -----------------------------------------------------------------------------
module bcd_digit_add
    import counter_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             inc,
    input  logic             carry_in,
    output logic [BCD_W-1:0] digit_out,
    output logic             carry_out
);

    // Sum never exceeds 9 + 1 + 1 = 11, so one subtraction of 10 suffices.
    logic [BCD_W:0] sum;

    assign sum       = {1'b0, digit} + {{BCD_W{1'b0}}, inc} + {{BCD_W{1'b0}}, carry_in};
    assign carry_out = (sum > {1'b0, BCD_MAX});
    assign digit_out = carry_out ? BCD_W'(sum - 5'd10) : sum[BCD_W-1:0];

endmodule

// File: rtl/bcd_digit_counter.sv
// -----------------------------------------------------------------------------
// bcd_digit_counter
// Multi-digit BCD counter. An increment pulse adds one unit at every digit
// whose trigger bit is set, walking the digits serially (one per cycle) with a
// single shared adder. A refresh pulse snapshots the settled value to disp.
//
// Ports:
//   clk        in  1         : system clock, rising edge
//   rst_n      in  1         : synchronous active-low reset
//   inc_pulse  in  1         : increment strobe (ignored while busy)
//   ref_pulse  in  1         : refresh strobe (deferred while busy)
//   trigger    in  DIGITS    : bit i adds +1 at digit i
//   clear      in  1         : synchronous clear of count, display, overflow
//   disp       out 4*DIGITS  : display snapshot, digit i at [4i+3:4i]
//   busy       out 1         : carry walk in progress
//   overflow   out 1         : sticky, carry left the top digit
//
// Build option: BCD_COUNTER_SATURATE_EN -- when defined, an overflowing walk
// pins every digit at 9 instead of wrapping modulo 10^DIGITS.
// DIGITS must be at least 2.
// -----------------------------------------------------------------------------
module bcd_digit_counter
    import counter_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inc_pulse,
    input  logic                    ref_pulse,
    input  logic [DIGITS-1:0]       trigger,
    input  logic                    clear,
    output logic [BCD_W*DIGITS-1:0] disp,
    output logic                    busy,
    output logic                    overflow
);

    localparam int               IDX_W    = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      carry_q, carry_d;
    logic                      final_carry_q, final_carry_d;
    logic [DIGITS-1:0]         inc_mask_q, inc_mask_d;
    logic [BCD_W*DIGITS-1:0]   working_q, working_d;
    logic [BCD_W*DIGITS-1:0]   disp_q, disp_d;
    logic                      overflow_q, overflow_d;
    logic                      ref_pending_q, ref_pending_d;
    logic                      busy_q, busy_d;

    logic [BCD_W-1:0]          add_digit;
    logic [BCD_W-1:0]          add_out;
    logic                      add_cout;

    // One adder shared by all digits, selected by the walk index.
    assign add_digit = working_q[int'(idx_q)*BCD_W +: BCD_W];

    bcd_digit_add u_add (
        .digit     (add_digit),
        .inc       (inc_mask_q[idx_q]),
        .carry_in  (carry_q),
        .digit_out (add_out),
        .carry_out (add_cout)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        carry_d       = carry_q;
        final_carry_d = final_carry_q;
        inc_mask_d    = inc_mask_q;
        working_d     = working_q;
        disp_d        = disp_q;
        overflow_d    = overflow_q;
        // A refresh arriving mid-walk is remembered until the walk settles.
        ref_pending_d = ref_pending_q | ref_pulse;

        unique case (state_q)
            IDLE: begin
                // Snapshot uses the pre-increment value if inc arrives too.
                if (ref_pulse || ref_pending_q) begin
                    disp_d        = working_q;
                    ref_pending_d = 1'b0;
                end
                if (inc_pulse) begin
                    inc_mask_d = trigger;
                    idx_d      = '0;
                    carry_d    = 1'b0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                working_d[int'(idx_q)*BCD_W +: BCD_W] = add_out;
                carry_d = add_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    final_carry_d = add_cout;
                    state_d       = DONE;
                end
            end
            DONE: begin
                if (final_carry_q) begin
                    overflow_d = 1'b1;
`ifdef BCD_COUNTER_SATURATE_EN
                    working_d  = {DIGITS{BCD_MAX}};
`endif
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Clear aborts any walk and wipes all visible state.
        if (clear) begin
            state_d       = IDLE;
            working_d     = '0;
            disp_d        = '0;
            overflow_d    = 1'b0;
            ref_pending_d = 1'b0;
            inc_mask_d    = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            carry_q       <= 1'b0;
            final_carry_q <= 1'b0;
            inc_mask_q    <= '0;
            working_q     <= '0;
            disp_q        <= '0;
            overflow_q    <= 1'b0;
            ref_pending_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            carry_q       <= carry_d;
            final_carry_q <= final_carry_d;
            inc_mask_q    <= inc_mask_d;
            working_q     <= working_d;
            disp_q        <= disp_d;
            overflow_q    <= overflow_d;
            ref_pending_q <= ref_pending_d;
            busy_q        <= busy_d;
        end
    end

    assign disp     = disp_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_digit_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_digit_counter
// Directed self-checking bench for bcd_digit_counter (DIGITS = 8).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. Edge T is the rising edge that samples inc_pulse; "slot k"
// is the falling edge between T+k and T+k+1.
// -----------------------------------------------------------------------------
module tb_bcd_digit_counter;

    localparam int DIGITS = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 inc_pulse;
    logic                 ref_pulse;
    logic [DIGITS-1:0]    trigger;
    logic                 clear;
    logic [4*DIGITS-1:0]  disp;
    logic                 busy;
    logic                 overflow;

    int asserts  = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_digit_counter #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_pulse (inc_pulse),
        .ref_pulse (ref_pulse),
        .trigger   (trigger),
        .clear     (clear),
        .disp      (disp),
        .busy      (busy),
        .overflow  (overflow)
    );

    // ---- stimulus helpers (no checking inside) ----
    task automatic step();
        @(posedge clk); #1;
    endtask

    // Issue one increment and wait until the walk has fully returned to IDLE.
    task automatic do_inc(input logic [DIGITS-1:0] t);
        trigger = t; inc_pulse = 1'b1;
        step();                 // edge T
        inc_pulse = 1'b0;
        repeat (10) step();     // past T+DIGITS+1
    endtask

    task automatic do_ref();
        ref_pulse = 1'b1;
        step();
        ref_pulse = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        @(negedge clk);
        asserts++; if (disp !== 32'h0) begin failures++; $display("FAIL reset_disp got=%h exp=%h", disp, 32'h0); end
        asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        asserts++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        step();
        do_ref();
        @(negedge clk);
        asserts++; if (disp !== 32'h0) begin failures++; $display("FAIL reset_ref_disp got=%h exp=%h", disp, 32'h0); end
    endtask

    task automatic test_single_unit();
        int busy_cnt;
        logic [31:0] d9, d10;
        busy_cnt = 0; d9 = '0; d10 = '0;
        step();
        do_clear();
        trigger = 8'h01; inc_pulse = 1'b1;
        step();                             // edge T
        inc_pulse = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (k == 9) begin d9 = disp; ref_pulse = 1'b1; end   // sampled at T+10
            if (k == 10) begin d10 = disp; ref_pulse = 1'b0; end
        end
        asserts++; if (busy_cnt !== 9) begin failures++; $display("FAIL single_busy_cycles got=%0d exp=9", busy_cnt); end
        asserts++; if (d9 !== 32'h0) begin failures++; $display("FAIL single_disp_before_ref got=%h exp=%h", d9, 32'h0); end
        asserts++; if (d10 !== 32'h0000_0001) begin failures++; $display("FAIL single_disp got=%h exp=%h", d10, 32'h1); end
        step();
    endtask

    task automatic test_carry_ripple();
        do_clear();
        repeat (9) do_inc(8'h07);           // 9 x 111 = 999
        do_inc(8'h01);                      // 999 + 1
        do_ref();
        @(negedge clk);
        asserts++; if (disp !== 32'h0000_1000) begin failures++; $display("FAIL ripple_disp got=%h exp=%h", disp, 32'h1000); end
        asserts++; if (overflow !== 1'b0) begin failures++; $display("FAIL ripple_ovf got=%b exp=0", overflow); end
        step();
    endtask

    task automatic test_multi_bit();
        do_clear();
        repeat (8) do_inc(8'h03);           // 88
        repeat (7) do_inc(8'h01);           // 95
        do_inc(8'h06);                      // +110
        do_ref();
        @(negedge clk);
        asserts++; if (disp !== 32'h0000_0205) begin failures++; $display("FAIL multi_disp got=%h exp=%h", disp, 32'h205); end
        step();
    endtask

    task automatic test_overflow();
        logic [31:0] exp_disp;
`ifdef BCD_COUNTER_SATURATE_EN
        exp_disp = 32'h9999_9999;
`else
        exp_disp = 32'h0000_0000;
`endif
        do_clear();
        repeat (9) do_inc(8'hFF);           // 9999_9999
        do_ref();
        @(negedge clk);
        asserts++; if (disp !== 32'h9999_9999) begin failures++; $display("FAIL ovf_preload got=%h exp=%h", disp, 32'h99999999); end
        step();
        do_inc(8'h01);
        do_ref();
        @(negedge clk);
        asserts++; if (disp !== exp_disp) begin failures++; $display("FAIL ovf_disp got=%h exp=%h", disp, exp_disp); end
        asserts++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        step();
    endtask

    task automatic test_ref_deferred();
        logic [31:0] d9, d10;
        d9 = '0; d10 = '0;
        do_clear();
        trigger = 8'h01; inc_pulse = 1'b1;
        step();                             // edge T
        inc_pulse = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 2) ref_pulse = 1'b1;   // sampled at T+3
            if (k == 3) ref_pulse = 1'b0;
            if (k == 9) d9 = disp;
            if (k == 10) d10 = disp;
        end
        asserts++; if (d9 !== 32'h0) begin failures++; $display("FAIL defer_early got=%h exp=%h", d9, 32'h0); end
        asserts++; if (d10 !== 32'h0000_0001) begin failures++; $display("FAIL defer_disp got=%h exp=%h", d10, 32'h1); end
        step();
    endtask

    task automatic test_clear_midwalk();
        logic b4;
        b4 = 1'bx;
        do_inc(8'h05);                      // working = 1 + 101 = 102
        trigger = 8'h01; inc_pulse = 1'b1;
        step();                             // edge T
        inc_pulse = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 3) clear = 1'b1;       // sampled at T+4
            if (k == 4) begin clear = 1'b0; b4 = busy; end
        end
        asserts++; if (b4 !== 1'b0) begin failures++; $display("FAIL clear_busy got=%b exp=0", b4); end
        asserts++; if (overflow !== 1'b0) begin failures++; $display("FAIL clear_ovf got=%b exp=0", overflow); end
        step();
        do_ref();
        @(negedge clk);
        asserts++; if (disp !== 32'h0) begin failures++; $display("FAIL clear_disp got=%h exp=%h", disp, 32'h0); end
        step();
    endtask

    task automatic test_back_to_back();
        do_clear();
        trigger = 8'h01; inc_pulse = 1'b1;
        step();                             // edge T
        inc_pulse = 1'b0;
        @(negedge clk);
        @(negedge clk);
        inc_pulse = 1'b1;                   // sampled at T+2, mid-walk
        step();
        inc_pulse = 1'b0;
        repeat (10) step();
        do_ref();
        @(negedge clk);
        asserts++; if (disp !== 32'h0000_0001) begin failures++; $display("FAIL b2b_disp got=%h exp=%h", disp, 32'h1); end
        step();
    endtask

    task automatic test_simultaneous();
        // working is 1 here; inc and ref together snapshot the old value.
        trigger = 8'h10; inc_pulse = 1'b1; ref_pulse = 1'b1;
        step();
        inc_pulse = 1'b0; ref_pulse = 1'b0;
        @(negedge clk);
        asserts++; if (disp !== 32'h0000_0001) begin failures++; $display("FAIL simul_pre got=%h exp=%h", disp, 32'h1); end
        repeat (10) step();
        do_ref();
        @(negedge clk);
        asserts++; if (disp !== 32'h0001_0001) begin failures++; $display("FAIL simul_post got=%h exp=%h", disp, 32'h10001); end
        step();
    endtask

    initial begin
        rst_n = 1'b0; inc_pulse = 1'b0; ref_pulse = 1'b0;
        trigger = '0; clear = 1'b0;
        #1;
        test_reset();
        test_single_unit();
        test_carry_ripple();
        test_multi_bit();
        test_overflow();
        test_ref_deferred();
        test_clear_midwalk();
        test_back_to_back();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/bcd_digit_counter.md
# bcd_digit_counter

Multi-digit BCD counter that consumes the increment and refresh pulses produced by the trigger clock scaler. Each increment pulse adds a place-value weighted amount, one unit at each digit whose trigger bit is set, to a DIGITS-wide BCD value using a serial digit-by-digit carry walk. Each refresh pulse snapshots the settled value into the display register that feeds the seven-segment multiplexer.

## Interface
- DIGITS, 8: number of BCD digits; also the trigger vector width.
- clk  in  1: system clock; all logic is on the rising edge.
- rst_n  in  1: synchronous, active-low reset.
- inc_pulse  in  1: single-cycle increment strobe from the clock scaler.
- ref_pulse  in  1: single-cycle refresh strobe from the clock scaler.
- trigger  in  DIGITS: synchronized button vector; bit i means "+1 at digit i".
- clear  in  1: synchronous clear of the count, display and overflow flag.
- disp  out  4*DIGITS: display snapshot; digit i is disp[4i+3:4i].
- busy  out  1: carry walk in progress.
- overflow  out  1: sticky; set when a carry leaves the top digit.

## Operation
- The working register holds DIGITS BCD digits. The display register `disp` changes only on a refresh.
- FSM states:
  - IDLE: when inc_pulse=1, latch trigger into inc_mask, set idx=0 and carry=0, go to CALC. When inc_mask would be 0, still walk; the value stays unchanged.
  - CALC: sum = digit[idx] + inc_mask[idx] + carry (maximum 11). When sum ≥ 10, write sum−10 and set carry=1; otherwise write sum and set carry=0. Increment idx. After digit DIGITS−1, go to DONE and latch final_carry.
  - DONE: when final_carry=1, set overflow. Go to IDLE.
- While not in IDLE, inc_pulse is ignored. Upstream spacing is at least 10 cycles.
- ref_pulse sets ref_pending in any state. In IDLE with ref_pending or ref_pulse set, copy disp <= working and clear ref_pending.
- clear has priority over everything except reset. It zeroes working, disp, overflow, ref_pending and inc_mask, and forces IDLE, aborting any walk.
- idx is $clog2(DIGITS) bits wide. Digits never hold values above 9.

## Timing
- Reset (rst_n=0 at an edge) forces IDLE and sets working=0, disp=0, busy=0, overflow=0, ref_pending=0. A reset mid-walk discards the partial result.
- inc_pulse is sampled at edge T:
  - edges T+1 … T+DIGITS process digits 0 … DIGITS−1;
  - edge T+DIGITS+1 executes DONE and returns to IDLE.
- busy=1 from after edge T through edge T+DIGITS+1. busy is registered: busy = (state != IDLE).
- With DIGITS ≤ 8 the scaler's ref_pulse (T+10) lands in IDLE. disp updates at that edge and is visible the next cycle.
- A ref_pulse during CALC or DONE defers to the first IDLE cycle.
- Simultaneous inc_pulse and ref_pulse in IDLE: disp gets the pre-increment value and the walk starts.

## Configuration
- BCD_COUNTER_SATURATE_EN:
  - Defined: in DONE with final_carry=1, every working digit is forced to 9, so the count saturates at all-nines. overflow is still set.
  - Undefined: the value wraps modulo 10^DIGITS and overflow is set.

## Structure
- Package `counter_pkg` holds:
  - the state enum (IDLE, CALC, DONE);
  - BCD_W=4;
  - BCD_MAX=4'd9.
- Sub-module `bcd_digit_add` is combinational. It takes digit, inc and carry_in, and returns digit_out and carry_out. There is one instance, muxed by idx.

## Test plan
- Reset then idle: rst_n low 2 cycles -> disp=0, busy=0, overflow=0; ref_pulse -> disp stays 0.
- Single unit: working=0, trigger=8'h01, inc_pulse, ref_pulse at T+10 -> busy high for 9 cycles, disp=32'h0000_0001 at T+11.
- Carry ripple: working=32'h0000_0999, trigger=8'h01 -> after walk, ref gives disp=32'h0000_1000 and overflow=0.
- Multi-bit: working=32'h0000_0095, trigger=8'h06 (+110) -> disp=32'h0000_0205.
- Overflow: working=32'h9999_9999, trigger=8'h01 -> without macro disp=0 and overflow=1; with BCD_COUNTER_SATURATE_EN disp=32'h9999_9999 and overflow=1.
- Interference:
  - ref_pulse at T+3 -> disp updates at T+DIGITS+2 with the new value.
  - clear at T+4 -> working=0, busy=0 next cycle.
  - second inc_pulse at T+2 -> ignored, only one increment applied.
